axi4_s_bus_wr_sequencer: RTL and testbench
==========================================

AXI4_S_BUS_WR_SEQUENCER -- requirements
Module: axi4_s_bus_wr_sequencer

Interface
REQ-001 SHALL have parameter A_W, default 32, address width.
REQ-002 SHALL have parameter D_W, default 32, data width (multiple of 8); S_W = D_W/8 strobe width.
REQ-003 SHALL have parameter BASE, default 0, first decoded byte address.
REQ-004 SHALL have parameter SIZE, default 'h1000, decoded window size in bytes.
REQ-005 SHALL have parameter TIMEOUT, default 255, max ack-wait cycles (8-bit; 0 disables timeout).
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 aw_rd_empty  in  1  AW FIFO empty; aw_addr  in  A_W  AW FIFO head (valid while not empty).
REQ-009 aw_rd_en  out  1  AW FIFO pop.
REQ-010 w_rd_empty  in  1; w_data  in  D_W; w_strb  in  S_W  W FIFO head (valid while not empty).
REQ-011 w_rd_en  out  1  W FIFO pop.
REQ-012 b_wr_full  in  1  B FIFO full; b_wr_en  out  1  B FIFO push; b_resp  out  2  response pushed.
REQ-013 reg_wr_req  out  1; reg_wr_addr  out  A_W; reg_wr_data  out  D_W; reg_wr_strb  out  S_W  register-write port.
REQ-014 reg_wr_ack  in  1  write accepted OK; reg_wr_err  in  1  write completed with error.
REQ-015 busy  out  1  high when state != IDLE.
REQ-016 wr_count  out  16; err_count  out  16  completed writes / non-OKAY responses.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: when !aw_rd_empty && !w_rd_empty, assert aw_rd_en and w_rd_en together for exactly that cycle, latch aw_addr, w_data, w_strb; never pop one FIFO without the other.
REQ-019 IDLE pop -> ISSUE if BASE <= addr < BASE+SIZE (unsigned, A_W+1-bit compare, no wrap), else -> RESP with b_resp=2'b11 (DECERR), no register write issued.
REQ-020 ISSUE: reg_wr_req=1 with latched addr/data/strb, timeout counter cleared; -> WAIT next cycle.
REQ-021 WAIT: reg_wr_req held 1, outputs stable; counter increments each cycle without ack/err.
REQ-022 reg_wr_ack or reg_wr_err sampled in ISSUE or WAIT ends the request: reg_wr_req=0 next cycle, -> RESP.
REQ-023 ack only -> b_resp 2'b00; err (with or without ack) -> b_resp 2'b10.
REQ-024 TIMEOUT!=0 and counter reaches TIMEOUT with no ack/err -> drop req, b_resp 2'b10, -> RESP; late ack/err afterward ignored.
REQ-025 RESP: b_wr_en = ~b_wr_full (combinational in RESP); on push -> IDLE; while b_wr_full, hold RESP and b_resp.
REQ-026 On B push: wr_count += 1; err_count += 1 if b_resp != 2'b00; both wrap 16'hFFFF -> 0.
REQ-027 Min latency: pop cycle T, reg_wr_req at T+1, ack at T+1 -> b_wr_en at T+2; next pop earliest T+3.
REQ-028 Exactly one B push per AW/W pair popped; transactions strictly in order, one outstanding.
REQ-029 aw_rd_en, w_rd_en, b_wr_en never asserted outside IDLE/RESP as above.

Reset
REQ-030 reset: state IDLE; aw_rd_en, w_rd_en, b_wr_en, reg_wr_req, busy = 0; b_resp, reg_wr_addr/data/strb, counters, timeout counter = 0.
REQ-031 reset mid-transaction abandons it: no B push, reg_wr_req=0 next cycle, counts unchanged from 0.
REQ-032 reset dominates all inputs in the same cycle.

Verification
REQ-033 Both FIFOs hold addr 'h10/data 'hA5A5A5A5/strb 'hF, ack same cycle as req -> req one cycle, b_resp 00 pushed at T+2, wr_count=1.
REQ-034 AW non-empty, W empty 20 cycles -> no pops, busy=0; W arrives -> both pop same cycle.
REQ-035 addr 'h1000 (BASE=0,SIZE='h1000) -> no reg_wr_req, b_resp 11, err_count=1.
REQ-036 No ack, TIMEOUT=4 -> req drops after counter hits 4, b_resp 10; ack 2 cycles later ignored.
REQ-037 b_wr_full held 5 cycles in RESP -> b_wr_en 0, b_resp stable, push on first non-full cycle; reset asserted in WAIT -> no push, all outputs 0.

Source files
------------

// File: rtl/axi4_s_bus_wr_sequencer.sv
// Drains paired AW/W FIFO entries into a single-beat register-write port.
// Each pair produces exactly one response, pushed into the B FIFO in order.
module axi4_s_bus_wr_sequencer #(
    parameter int              A_W     = 32,
    parameter int              D_W     = 32,
    parameter longint unsigned BASE    = 0,
    parameter longint unsigned SIZE    = 'h1000,
    parameter int              TIMEOUT = 255,
    localparam int             S_W     = D_W / 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           aw_rd_empty,
    input  logic [A_W-1:0] aw_addr,
    output logic           aw_rd_en,
    input  logic           w_rd_empty,
    input  logic [D_W-1:0] w_data,
    input  logic [S_W-1:0] w_strb,
    output logic           w_rd_en,
    input  logic           b_wr_full,
    output logic           b_wr_en,
    output logic [1:0]     b_resp,
    output logic           reg_wr_req,
    output logic [A_W-1:0] reg_wr_addr,
    output logic [D_W-1:0] reg_wr_data,
    output logic [S_W-1:0] reg_wr_strb,
    input  logic           reg_wr_ack,
    input  logic           reg_wr_err,
    output logic           busy,
    output logic [15:0]    wr_count,
    output logic [15:0]    err_count,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    // Window bounds are one bit wider than the address so BASE+SIZE never wraps.
    localparam logic [A_W:0] WIN_LO = (A_W + 1)'(BASE);
    localparam logic [A_W:0] WIN_HI = (A_W + 1)'(BASE + SIZE);
    localparam logic [7:0]   TMO    = 8'(TIMEOUT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Handshakes: a FIFO pop or B push takes effect on the rising edge during
    // which its enable is high; the FIFO heads are only read while not empty.
    state_t         state_q, state_d;
    logic [A_W-1:0] addr_q, addr_d;
    logic [D_W-1:0] data_q, data_d;
    logic [S_W-1:0] strb_q, strb_d;
    logic           req_q, req_d;
    logic [1:0]     resp_q, resp_d;
    logic [7:0]     tmo_q, tmo_d;
    logic [15:0]    wr_cnt_q, wr_cnt_d;
    logic [15:0]    err_cnt_q, err_cnt_d;
    logic           pop, push, in_win;
    logic [7:0]     tmo_inc;

    assign in_win  = ({1'b0, aw_addr} >= WIN_LO) && ({1'b0, aw_addr} < WIN_HI);
    assign tmo_inc = tmo_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        req_d     = req_q;
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        pop       = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!aw_rd_empty && !w_rd_empty) begin
                    pop    = 1'b1;
                    addr_d = aw_addr;
                    data_d = w_data;
                    strb_d = w_strb;
                    tmo_d  = 8'd0;
                    if (in_win) begin
                        state_d = ISSUE;
                        req_d   = 1'b1;
                    end else begin
                        state_d = RESP;
                        resp_d  = RESP_DECERR;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (reg_wr_err || reg_wr_ack) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    resp_d  = reg_wr_err ? RESP_SLVERR : RESP_OKAY;
                end else if (TMO != 8'd0 && tmo_inc == TMO) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    resp_d  = RESP_SLVERR;
                    tmo_d   = tmo_inc;
                end else begin
                    state_d = WAIT;
                    tmo_d   = tmo_inc;
                end
            end
            RESP: begin
                if (!b_wr_full) begin
                    push     = 1'b1;
                    wr_cnt_d = wr_cnt_q + 16'd1;
                    if (resp_q != RESP_OKAY) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            req_q     <= 1'b0;
            resp_q    <= 2'b00;
            tmo_q     <= 8'd0;
            wr_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            req_q     <= req_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Reset masks the combinational strobes so nothing moves in the reset cycle.
    assign aw_rd_en    = pop && !reset;
    assign w_rd_en     = pop && !reset;
    assign b_wr_en     = push && !reset;
    assign b_resp      = resp_q;
    assign reg_wr_req  = req_q;
    assign reg_wr_addr = addr_q;
    assign reg_wr_data = data_q;
    assign reg_wr_strb = strb_q;
    assign busy        = (state_q != IDLE);
    assign wr_count    = wr_cnt_q;
    assign err_count   = err_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_axi4_s_bus_wr_sequencer.sv
// Bench for axi4_s_bus_wr_sequencer: queue-backed FIFOs, a responder driven per
// transaction, and an expected-response queue computed from the window/timeout rules.
module tb_axi4_s_bus_wr_sequencer;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aw_rd_empty = 1'b1;
  logic [31:0] aw_addr = '0;
  logic        aw_rd_en;
  logic        w_rd_empty = 1'b1;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_rd_en;
  logic        b_wr_full = 1'b0;
  logic        b_wr_en;
  logic [1:0]  b_resp;
  logic        reg_wr_req;
  logic [31:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_ack = 1'b0;
  logic        reg_wr_err = 1'b0;
  logic        busy;
  logic [15:0] wr_count;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;

  axi4_s_bus_wr_sequencer #(
    .A_W(32), .D_W(32), .BASE(0), .SIZE('h1000), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .aw_rd_empty(aw_rd_empty), .aw_addr(aw_addr), .aw_rd_en(aw_rd_en),
    .w_rd_empty(w_rd_empty), .w_data(w_data), .w_strb(w_strb), .w_rd_en(w_rd_en),
    .b_wr_full(b_wr_full), .b_wr_en(b_wr_en), .b_resp(b_resp),
    .reg_wr_req(reg_wr_req), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_wr_ack(reg_wr_ack), .reg_wr_err(reg_wr_err),
    .busy(busy), .wr_count(wr_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [1:0]  exp_q[$];
  logic [1:0]  got_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int unsigned model_wr = 0;
  int unsigned model_err = 0;
  logic s_pop_aw, s_pop_w, s_push;
  logic [1:0] s_resp;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    aw_rd_empty = (aw_q.size() == 0);
    aw_addr     = aw_rd_empty ? 32'h0 : aw_q[0];
    w_rd_empty  = (w_q.size() == 0);
    w_data      = w_rd_empty ? 32'h0 : w_q[0][31:0];
    w_strb      = w_rd_empty ? 4'h0 : w_q[0][35:32];
  endtask

  // One clock: sample strobes mid-cycle, then apply FIFO effects after the edge.
  task automatic cyc();
    @(negedge clk);
    s_pop_aw = aw_rd_en;
    s_pop_w  = w_rd_en;
    s_push   = b_wr_en;
    s_resp   = b_resp;
    @(posedge clk);
    #1;
    if (s_pop_aw && aw_q.size() > 0) aw_q.delete(0);
    if (s_pop_w && w_q.size() > 0) w_q.delete(0);
    if (s_push) got_q.push_back(s_resp);
    refresh();
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int dly, input bit use_ack, input bit use_err,
                         input int full_n, input bit aw_pre);
    bit inwin, resp_ok, pushed, was_full, in_resp;
    logic [1:0] er;
    int exp_req, req_n, pop_n, k, post, full_left, bad;
    inwin   = (a < 32'h1000);
    resp_ok = (use_ack || use_err) && (dly < TMO);
    er      = !inwin ? 2'b11 : (resp_ok ? (use_err ? 2'b10 : 2'b00) : 2'b10);
    exp_req = !inwin ? 0 : (resp_ok ? dly + 1 : TMO);
    exp_q.push_back(er);
    model_wr++;
    if (er != 2'b00) model_err++;
    req_n = 0; pop_n = 0; k = -1; post = 0; full_left = full_n; bad = 0; pushed = 0;
    if (!aw_pre) aw_q.push_back(a);
    w_q.push_back({s, d});
    refresh();
    for (int c = 0; c < 60 && post < 3; c++) begin
      if (reg_wr_req) begin
        req_n++;
        if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== {a, d, s}) bad++;
      end
      if (k >= 0) k++;
      else if (reg_wr_req) k = 0;
      reg_wr_ack = use_ack && (k == dly);
      reg_wr_err = use_err && (k == dly);
      in_resp  = busy && !reg_wr_req;
      was_full = in_resp && (full_left > 0);
      b_wr_full = was_full;
      if (was_full) full_left--;
      cyc();
      pop_n += int'(s_pop_aw);
      if (s_pop_aw !== s_pop_w) bad++;
      if (was_full && (s_push !== 1'b0 || s_resp !== er)) bad++;
      if (in_resp && !was_full && s_push !== 1'b1) bad++;
      if (pushed) post++;
      if (s_push) pushed = 1;
    end
    reg_wr_ack = 0;
    reg_wr_err = 0;
    b_wr_full  = 0;
    check("pop_count", pop_n, 1);
    check("req_cycles", req_n, exp_req);
    check("protocol", bad, 0);
    check("push_count", got_q.size(), 1);
    if (got_q.size() > 0 && exp_q.size() > 0) check("b_resp", got_q[0], exp_q[0]);
    got_q.delete();
    exp_q.delete();
    check("wr_count", wr_count, model_wr & 16'hFFFF);
    check("err_count", err_count, model_err & 16'hFFFF);
  endtask

  initial begin
    int pops, busy_seen;
    logic [31:0] ra;

    // reset
    reset = 1;
    refresh();
    cyc();
    cyc();
    reset = 0;
    check("rst_busy", busy, 0);
    check("rst_req", reg_wr_req, 0);
    check("rst_addr", reg_wr_addr, 0);
    check("rst_data", reg_wr_data, 0);
    check("rst_strb", reg_wr_strb, 0);
    check("rst_resp", b_resp, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_err_count", err_count, 0);

    // minimum-latency write with immediate ack
    aw_q.push_back(32'h10);
    w_q.push_back({4'hF, 32'hA5A5A5A5});
    refresh();
    cyc();
    check("min_pop_aw", s_pop_aw, 1);
    check("min_pop_w", s_pop_w, 1);
    check("min_req_T1", reg_wr_req, 1);
    check("min_addr", reg_wr_addr, 32'h10);
    check("min_data", reg_wr_data, 32'hA5A5A5A5);
    check("min_strb", reg_wr_strb, 4'hF);
    reg_wr_ack = 1;
    cyc();
    reg_wr_ack = 0;
    check("min_no_push_T1", s_push, 0);
    check("min_req_T2", reg_wr_req, 0);
    cyc();
    check("min_push_T2", s_push, 1);
    check("min_resp", s_resp, 2'b00);
    check("min_wr_count", wr_count, 1);
    check("min_busy", busy, 0);
    got_q.delete();
    model_wr = 1;

    // AW waiting without W: nothing pops
    aw_q.push_back(32'h20);
    refresh();
    pops = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      pops += int'(s_pop_aw) + int'(s_pop_w);
      busy_seen += int'(busy);
    end
    check("aw_only_pops", pops, 0);
    check("aw_only_busy", busy_seen, 0);
    run_txn(32'h20, 32'h12345678, 4'h3, 1, 1, 0, 0, 1);

    // decode miss, timeout with late ack, B FIFO back-pressure
    run_txn(32'h1000, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 0);
    run_txn(32'h40, 32'hCAFEF00D, 4'hC, 5, 1, 0, 0, 0);
    run_txn(32'h44, 32'h0BADF00D, 4'h1, 2, 1, 0, 5, 0);
    run_txn(32'hFFC, 32'h11112222, 4'h6, 0, 1, 1, 0, 0);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'hFFF;
        1: ra = 32'h1000;
        2: ra = $urandom;
        default: ra = $urandom_range(0, 32'hFFF);
      endcase
      run_txn(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 3), 0);
    end

    // reset while a request is waiting
    aw_q.push_back(32'h80);
    w_q.push_back({4'hF, 32'h55AA55AA});
    refresh();
    cyc();
    cyc();
    check("wait_req", reg_wr_req, 1);
    reset = 1;
    cyc();
    check("rst_wait_no_push", s_push, 0);
    reset = 0;
    check("rst_wait_req", reg_wr_req, 0);
    check("rst_wait_busy", busy, 0);
    check("rst_wait_resp", b_resp, 0);
    check("rst_wait_addr", reg_wr_addr, 0);
    check("rst_wait_data", reg_wr_data, 0);
    check("rst_wait_wr_count", wr_count, 0);
    check("rst_wait_err_count", err_count, 0);
    for (int i = 0; i < 4; i++) cyc();
    check("rst_wait_pushes", got_q.size(), 0);
    check("rst_wait_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
